spram_word_ctrl: RTL and testbench
==================================

// Module: spram_word_ctrl
// PURPOSE
//  Initiator for one 16-bit SB_SPRAM256KA port. It accepts 32-bit word load and store
//  requests from the RV32I pipeline's data or instruction memory stage.
//  Each word is split into two halfword SPRAM beats: low half first, then high half.
//  Read halves are reassembled into a 32-bit response.
//  The controller handles the SPRAM's 1-cycle registered read latency and its nibble write mask.
// PARAMETERS
//  ADDR_W     13  word-address width; SPRAM address = {req_addr, half}; must be <= 13
//  SKIP_HALF  1   1: a store whose strobes touch only one half issues only that beat
// PORTS
//  clk             in   1       system clock; all state changes on posedge
//  reset           in   1       asynchronous, active-high reset
//  req_valid       in   1       request present
//  req_ready       out  1       request accepted when req_valid & req_ready
//  req_we          in   1       1 = store, 0 = load
//  req_addr        in   ADDR_W  word address
//  req_wstrb       in   4       byte strobes; ignored for loads
//  req_wdata       in   32      store data
//  rsp_valid       out  1       response present; held until rsp_ready
//  rsp_ready       in   1       response consumed when rsp_valid & rsp_ready
//  rsp_rdata       out  32      load data; unchanged by stores
//  spram_addr      out  14      to SPRAM addr
//  spram_din       out  16      to SPRAM din
//  spram_maskwren  out  4       to SPRAM maskwren; one bit per nibble
//  spram_wren      out  1       to SPRAM wren
//  spram_dout      in   16      from SPRAM dout; valid the cycle after a wren=0 beat
// BEHAVIOUR
//  - Reset values:
//    - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0.
//    - spram_wren = 0, spram_maskwren = 0, spram_addr = 0, spram_din = 0.
//  - Accept: in IDLE, req_ready = 1. A handshake latches we, addr, wstrb and wdata.
//    - req_ready = 0 in every other state, so there is at most one request outstanding.
//  - FSM states: IDLE, LO, HI, RDLAST, RESP.
//    - Load:  IDLE -> LO -> HI -> RDLAST -> RESP.
//    - Store: IDLE -> LO -> HI -> RESP.
//      - With SKIP_HALF=1 and wstrb[3:2]=0, HI is skipped: LO -> RESP.
//      - With SKIP_HALF=1 and wstrb[1:0]=0, LO is skipped: IDLE -> HI.
//      - With SKIP_HALF=1 and wstrb=0, both beats are skipped: IDLE -> RESP.
//      - With SKIP_HALF=0, a store always issues both beats.
//    - RESP -> IDLE on rsp_ready.
//  - SPRAM drive is combinational from state and the latched request:
//    - LO: addr = {a,0}, din = wdata[15:0].
//    - HI: addr = {a,1}, din = wdata[31:16].
//    - wren = we in LO/HI, 0 in every other state.
//    - maskwren nibble pair {2k+1,2k} = the byte strobe of that half; 0 for loads.
//    - In IDLE/RDLAST/RESP: wren = 0, maskwren = 0; addr and din hold their last values.
//  - Read capture:
//    - In HI, spram_dout holds the low half; latch it into rsp_rdata[15:0].
//    - In RDLAST, latch spram_dout into rsp_rdata[31:16].
//  - Latency, handshake in cycle T:
//    - load: rsp_valid at T+4.
//    - full store: rsp_valid at T+3.
//    - single-half store: rsp_valid at T+2.
//    - zero-strobe store: rsp_valid at T+1.
//  - rsp_valid and rsp_rdata are stable until consumed.
//    - A new req is not accepted in the same cycle as the rsp handshake; IDLE follows.
//  - A store response leaves rsp_rdata at its previous value.
//  - Asynchronous reset mid-operation:
//    - FSM returns to IDLE and spram_wren drops to 0 immediately.
//    - An in-flight beat may be partially committed; no response is produced.
// STRUCTURE
//  - spram_pkg holds:
//    - state encodings ST_IDLE, ST_LO, ST_HI, ST_RDLAST, ST_RESP;
//    - SPRAM_AW = 14 and SPRAM_DW = 16.
//  - Sub-module spram_strobe2mask: combinational 2-bit byte strobe -> 4-bit nibble mask.
//    - Instantiated once, fed with the half selected by state.
//  - Everything else is a single FSM plus request and read-data registers.
// TESTING
//  - Bench pairs this block with the SB_SPRAM256KA behavioural model; a scoreboard checks rsp_rdata.
//  1. Reset while idle: req_ready = 1, rsp_valid = 0, spram_wren = 0.
//     Then load addr 0 -> rsp_rdata = preload, rsp_valid at T+4.
//  2. Full store: addr 0x005, data 0xDEADBEEF, wstrb 0xF.
//     -> wren in 2 cycles at spram_addr 0x00A/0x00B.
//     Reading the same address back returns 0xDEADBEEF.
//  3. Partial stores on word 0x0DEADBEEF, SKIP_HALF=1:
//     - wstrb 0x4, wdata 0x00AA0000 -> one beat at addr {a,1}, maskwren 0x3.
//       Word reads 0xDEAABEEF; response at T+2.
//     - wstrb 0x0 -> no wren, rsp_valid at T+1.
//  4. Backpressure: hold rsp_ready = 0 for 5 cycles.
//     -> rsp_valid and rsp_rdata stable, req_ready = 0.
//     Releasing rsp_ready -> IDLE, next request accepted.
//  5. Top address 0x1FFF: store, then load 0x12345678 -> spram_addr 0x3FFE/0x3FFF, readback matches.
//  6. Assert reset during the HI beat of a store.
//     -> spram_wren = 0 in the same cycle, FSM in IDLE, no rsp_valid.
//     The next load completes correctly.

Source files
------------

// File: rtl/spram_pkg.sv
// Shared types and sizes for the 32-bit word controller driving one 16-bit SPRAM port.
package spram_pkg;

    localparam int unsigned SPRAM_AW = 14;
    localparam int unsigned SPRAM_DW = 16;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STRB_W   = 4;
    localparam int unsigned MASK_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LO     = 3'd1,
        ST_HI     = 3'd2,
        ST_RDLAST = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/spram_word_ctrl_if.sv
// Request/response handshake between the pipeline memory stage and the SPRAM word controller.
interface spram_word_ctrl_if
    import spram_pkg::*;
#(
    parameter int unsigned ADDR_W = 13
) ();

    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [STRB_W-1:0]   req_wstrb;
    logic [WORD_W-1:0]   req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [WORD_W-1:0]   rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/spram_strobe2mask.sv
// Expands the two byte strobes of one halfword into the SPRAM's four nibble write enables.
module spram_strobe2mask
    import spram_pkg::*;
(
    input  logic [1:0]        strb,
    output logic [MASK_W-1:0] mask
);

    always_comb begin
        mask = {{2{strb[1]}}, {2{strb[0]}}};
    end

endmodule

// File: rtl/spram_word_ctrl.sv
// Splits 32-bit loads/stores into low-then-high halfword SPRAM beats and reassembles read data.
module spram_word_ctrl
    import spram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter bit          SKIP_HALF = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    spram_word_ctrl_if.slave    bus,
    output logic [SPRAM_AW-1:0] spram_addr,
    output logic [SPRAM_DW-1:0] spram_din,
    output logic [MASK_W-1:0]   spram_maskwren,
    output logic                spram_wren,
    input  logic [SPRAM_DW-1:0] spram_dout
);

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [WORD_W-1:0]     wdata_q, wdata_d;
    logic [WORD_W-1:0]     rdata_q, rdata_d;
    logic [SPRAM_AW-1:0]   last_addr_q, last_addr_d;
    logic [SPRAM_DW-1:0]   last_din_q, last_din_d;

    logic                  in_beat;
    logic                  hi_sel;
    logic [1:0]            strb_half;
    logic [MASK_W-1:0]     half_mask;

    spram_strobe2mask u_mask (
        .strb (strb_half),
        .mask (half_mask)
    );

    // Next state, request latch and read-data capture
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wstrb_d = bus.req_wstrb;
                    wdata_d = bus.req_wdata;
                    if (!bus.req_we || !SKIP_HALF || (|bus.req_wstrb[1:0]))
                        state_d = ST_LO;
                    else if (|bus.req_wstrb[3:2])
                        state_d = ST_HI;
                    else
                        state_d = ST_RESP;
                end
            end
            ST_LO: begin
                if (!we_q || !SKIP_HALF || (|wstrb_q[3:2]))
                    state_d = ST_HI;
                else
                    state_d = ST_RESP;
            end
            ST_HI: begin
                // Low-half read issued in LO is on dout now
                if (!we_q) begin
                    rdata_d[15:0] = spram_dout;
                    state_d       = ST_RDLAST;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RDLAST: begin
                rdata_d[31:16] = spram_dout;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // SPRAM drive; address and data hold their last beat value between beats
    always_comb begin
        in_beat        = (state_q == ST_LO) || (state_q == ST_HI);
        hi_sel         = (state_q == ST_HI);
        strb_half      = hi_sel ? wstrb_q[3:2] : wstrb_q[1:0];
        spram_wren     = in_beat && we_q;
        spram_maskwren = spram_wren ? half_mask : '0;
        spram_addr     = in_beat ? SPRAM_AW'({addr_q, hi_sel}) : last_addr_q;
        spram_din      = in_beat ? (hi_sel ? wdata_q[31:16] : wdata_q[15:0]) : last_din_q;
        last_addr_d    = spram_addr;
        last_din_d     = spram_din;
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wstrb_q     <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            last_addr_q <= '0;
            last_din_q  <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            last_addr_q <= last_addr_d;
            last_din_q  <= last_din_d;
        end
    end

endmodule

// File: tb/tb_spram_word_ctrl.sv
// Bench for spram_word_ctrl: SPRAM behavioural model plus a byte-level word reference model.
module tb_spram_word_ctrl;
    import spram_pkg::*;

    localparam int unsigned AW = 13;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spram_word_ctrl_if #(.ADDR_W(AW)) bus ();

    logic [SPRAM_AW-1:0] spram_addr;
    logic [SPRAM_DW-1:0] spram_din;
    logic [SPRAM_DW-1:0] spram_dout;
    logic [MASK_W-1:0]   spram_maskwren;
    logic                spram_wren;

    spram_word_ctrl #(.ADDR_W(AW), .SKIP_HALF(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .spram_addr     (spram_addr),
        .spram_din      (spram_din),
        .spram_maskwren (spram_maskwren),
        .spram_wren     (spram_wren),
        .spram_dout     (spram_dout)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] words [8192];
    logic [15:0] mem   [16384];
    logic        preload = 1'b0;
    logic [31:0] last_rdata;
    logic [17:0] wlog [$];

    // SB_SPRAM256KA-like model: registered read, nibble-masked write
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8192; i++) begin
                mem[2*i]   <= words[i][15:0];
                mem[2*i+1] <= words[i][31:16];
            end
        end else if (spram_wren) begin
            for (int k = 0; k < 4; k++)
                if (spram_maskwren[k]) mem[spram_addr][4*k +: 4] <= spram_din[4*k +: 4];
        end else begin
            spram_dout <= mem[spram_addr];
        end
        if (spram_wren) wlog.push_back({spram_addr, spram_maskwren});
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] nib_mask(input logic [1:0] b);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = b[i/2];
        return m;
    endfunction

    task automatic txn(input logic we, input logic [12:0] a, input logic [3:0] s,
                       input logic [31:0] d, input int hold, input string tag);
        int lat, base, waitc, wlo, whi, exp_lat;
        logic [31:0] exp_rd;
        waitc = 0;
        while (bus.req_ready !== 1'b1 && waitc < 20) begin @(posedge clk); #1; waitc++; end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        base = wlog.size();
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wstrb = s;
        bus.req_wdata = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        wlo = (we && (|s[1:0])) ? 1 : 0;
        whi = (we && (|s[3:2])) ? 1 : 0;
        exp_lat = we ? 1 + wlo + whi : 4;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (we) begin
            for (int j = 0; j < 4; j++)
                if (s[j]) words[a][8*j +: 8] = d[8*j +: 8];
            exp_rd = last_rdata;
        end else begin
            exp_rd = words[a];
            last_rdata = exp_rd;
        end
        chk({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        chk({tag, "_nbeats"}, 32'(wlog.size() - base), 32'(wlo + whi));
        if (wlo == 1 && wlog.size() > base)
            chk({tag, "_lobeat"}, 32'(wlog[base]), 32'({a, 1'b0, nib_mask(s[1:0])}));
        if (whi == 1 && wlog.size() > base)
            chk({tag, "_hibeat"}, 32'(wlog[wlog.size()-1]), 32'({a, 1'b1, nib_mask(s[3:2])}));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            chk({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
            chk({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_post_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int b6;
        logic [31:0] old7;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wstrb = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8192; i++) words[i] = $urandom;
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        last_rdata = 32'd0;

        // 1: reset state, then preload readback
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_wren",      32'(spram_wren), 32'd0);
        chk("rst_mask",      32'(spram_maskwren), 32'd0);
        chk("rst_addr",      32'(spram_addr), 32'd0);
        chk("rst_din",       32'(spram_din), 32'd0);
        chk("rst_rdata",     bus.rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 13'h0000, 4'h0, 32'h0, 0, "t1_load0");

        // 2: full store and readback
        txn(1'b1, 13'h0005, 4'hF, 32'hDEADBEEF, 0, "t2_store");
        txn(1'b0, 13'h0005, 4'h0, 32'h0, 0, "t2_load");
        chk("t2_word", bus.rsp_rdata, 32'hDEADBEEF);

        // 3: single-half and zero-strobe stores
        txn(1'b1, 13'h0005, 4'h4, 32'h00AA0000, 0, "t3_hi_only");
        txn(1'b0, 13'h0005, 4'h0, 32'h0, 0, "t3_load");
        chk("t3_word", bus.rsp_rdata, 32'hDEAABEEF);
        txn(1'b1, 13'h0005, 4'h0, 32'h11111111, 0, "t3_zero");
        txn(1'b1, 13'h0005, 4'h3, 32'h00001234, 0, "t3_lo_only");
        txn(1'b0, 13'h0005, 4'h0, 32'h0, 0, "t3_load2");

        // 4: response backpressure
        txn(1'b0, 13'h0005, 4'h0, 32'h0, 5, "t4_bp");
        txn(1'b0, 13'h0000, 4'h0, 32'h0, 0, "t4_next");

        // 5: top word address
        txn(1'b1, 13'h1FFF, 4'hF, 32'h12345678, 0, "t5_store");
        txn(1'b0, 13'h1FFF, 4'h0, 32'h0, 0, "t5_load");
        chk("t5_word", bus.rsp_rdata, 32'h12345678);

        // 6: reset asserted during the high beat of a store
        old7 = words[7];
        b6 = wlog.size();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 13'h0007;
        bus.req_wstrb = 4'hF;
        bus.req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_hi_addr", 32'(spram_addr), 32'h0000000F);
        chk("t6_hi_wren", 32'(spram_wren), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_wren",  32'(spram_wren), 32'd0);
        chk("t6_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("t6_rst_rdata", bus.rsp_rdata, 32'd0);
        last_rdata = 32'd0;
        words[7] = {old7[31:16], 16'hF00D};
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("t6_beats", 32'(wlog.size() - b6), 32'd1);
        txn(1'b0, 13'h0007, 4'h0, 32'h0, 0, "t6_load");

        // Random mix against the word model
        for (int n = 0; n < 40; n++) begin
            logic        rwe;
            logic [12:0] ra;
            rwe = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? 13'h1FFF : 13'($urandom_range(0, 15));
            txn(rwe, ra, 4'($urandom), $urandom, int'($urandom_range(0, 2)), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
